// File: rtl/uart_pkg.sv
// Shared types and parity helper for the configurable UART transmitter.
package uart_pkg;

    localparam int MAX_DW = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Narrower words are zero-extended by the caller; zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DW-1:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with combinational read of the head entry.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, LSB-first data, optional parity, 1/2 stops.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
import uart_pkg::*;

module uart_tx_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [1:0]            parity_mode,
    input  logic                  stop2,
    output logic                  tx_sig,
    output logic                  busy
);
    localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W       = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int IDX_W       = $clog2(DATA_WIDTH);

    tx_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en, par_bit, stop2_q, stop_sec;

    logic                  word_avail, start_frame, last_tick, frame_end;
    logic [DATA_WIDTH-1:0] word;
    logic [MAX_DW-1:0]     word_ext;
    parity_e               pmode;

    assign pmode       = parity_e'(parity_mode);
    assign word_ext    = MAX_DW'(word);
    assign last_tick   = (cnt == CNT_W'(PULSE_WIDTH - 1));
    assign frame_end   = (state == STOP) & last_tick & (~stop2_q | stop_sec);
    // A pending word at the end of the last stop bit starts the next frame without an idle bit.
    assign start_frame = word_avail & ((state == IDLE) | frame_end);

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty, alive_q;

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_valid & tx_ready),
        .pop   (start_frame),
        .wdata (tx_data),
        .rdata (word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Keeps tx_ready low while reset is asserted even though the FIFO reads empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) alive_q <= 1'b0;
        else       alive_q <= 1'b1;
    end

    assign tx_ready   = alive_q & ~fifo_full;
    assign word_avail = ~fifo_empty;
    assign busy       = (state != IDLE) | ~fifo_empty;
`else
    logic rdy_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rdy_q <= 1'b0;
        else       rdy_q <= ~start_frame & ((state == IDLE) | frame_end);
    end

    assign tx_ready   = rdy_q;
    assign word_avail = tx_valid & rdy_q;
    assign word       = tx_data;
    assign busy       = (state != IDLE);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tx_sig   <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            stop_sec <= 1'b0;
        end else if (start_frame) begin
            // Frame configuration is frozen here; later input changes wait for the next word.
            state    <= START;
            tx_sig   <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= word;
            par_en   <= (pmode == PAR_EVEN) | (pmode == PAR_ODD);
            par_bit  <= calc_parity(word_ext, pmode);
            stop2_q  <= stop2;
            stop_sec <= 1'b0;
        end else if (state != IDLE) begin
            cnt <= last_tick ? '0 : cnt + 1'b1;
            if (last_tick) begin
                case (state)
                    START: begin
                        state  <= DATA;
                        tx_sig <= shreg[0];
                    end
                    DATA: begin
                        if (idx == IDX_W'(DATA_WIDTH - 1)) begin
                            if (par_en) begin
                                state  <= PARITY;
                                tx_sig <= par_bit;
                            end else begin
                                state  <= STOP;
                                tx_sig <= 1'b1;
                            end
                        end else begin
                            idx    <= idx + 1'b1;
                            shreg  <= shreg >> 1;
                            tx_sig <= shreg[1];
                        end
                    end
                    PARITY: begin
                        state  <= STOP;
                        tx_sig <= 1'b1;
                    end
                    STOP: begin
                        if (frame_end) state    <= IDLE;
                        else           stop_sec <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomised scoreboard bench for uart_tx_cfg; a monitor decodes tx_sig against a frame model.
module tb_uart_tx_cfg;
    localparam int PW  = 5;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       s2;
    } item_t;

    logic       clk, rstn, tx_valid, tx_ready, stop2, tx_sig, busy;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;

    int    checks = 0;
    int    errors = 0;
    item_t sb[$];
    bit    mon_in = 0;

    uart_tx_cfg #(
        .DATA_WIDTH(8),
        .CLK_FREQ  (50),
        .BAUD_RATE (10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .tx_sig     (tx_sig),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: expected line bits come from the frame rules, sampled every cycle of every bit.
    initial begin
        bit   bits[$];
        bit   prev, bad, got_bad;
        int   pos, ones;
        item_t it;
        prev = 1;
        bad  = 0;
        got_bad = 0;
        pos  = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                mon_in = 0;
                prev   = 1;
                bad    = 0;
            end else begin
                if (!mon_in && prev && !tx_sig) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_frame: start bit with no word queued");
                    end else begin
                        it = sb.pop_front();
                        bits = {};
                        bits.push_back(1'b0);
                        for (int i = 0; i < 8; i++) bits.push_back(it.d[i]);
                        ones = $countones(it.d);
                        if (it.m == 2'd1) bits.push_back(bit'(ones % 2));
                        else if (it.m == 2'd2) bits.push_back(bit'(1 - ones % 2));
                        bits.push_back(1'b1);
                        if (it.s2) bits.push_back(1'b1);
                        mon_in = 1;
                        pos    = 0;
                        bad    = 0;
                    end
                end
                if (mon_in) begin
                    if (tx_sig != bits[pos / PW]) begin
                        bad = 1;
                        got_bad = tx_sig;
                    end
                    if (pos % PW == PW - 1) begin
                        checks++;
                        if (bad) begin
                            errors++;
                            $display("FAIL frame_bit: data=%02h mode=%0d stop2=%0d bit %0d got %0b expected %0b",
                                     it.d, it.m, it.s2, pos / PW, got_bad, bits[pos / PW]);
                        end
                        bad = 0;
                    end
                    pos++;
                    if (pos == bits.size() * PW) mon_in = 0;
                end
                prev = tx_sig;
            end
        end
    end

    task automatic send(input logic [7:0] d, output int waits);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1;
        waits    = 0;
        while (!tx_ready && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (!tx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tx_ready stayed 0 for data %02h", d);
        end else begin
            sb.push_back('{d, parity_mode, stop2});
        end
        @(posedge clk);
        #1 tx_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0 || mon_in) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b queued=%0d", busy, sb.size());
        end
    endtask

    // Single frame from idle: checks start latency and busy length against the frame-length formula.
    task automatic single_frame(input logic [7:0] d, input logic [1:0] m, input logic s2);
        int w, n, nb;
        wait_idle();
        parity_mode = m;
        stop2       = s2;
        send(d, w);
        @(negedge clk);
        chk("start_latency", int'(tx_sig), (LAT == 0) ? 0 : 1);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        nb = 1 + 8 + ((m == 2'd1 || m == 2'd2) ? 1 : 0) + (s2 ? 2 : 1);
        chk("busy_length", n, nb * PW + LAT);
    endtask

    initial begin
        int w, n;
        clk = 0;
        rstn = 0;
        tx_valid = 0;
        tx_data = 0;
        parity_mode = 0;
        stop2 = 0;
        #12;
        chk("reset_tx_sig", int'(tx_sig), 1);
        chk("reset_tx_ready", int'(tx_ready), 0);
        chk("reset_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        chk("ready_after_release", int'(tx_ready), 1);

        // Known frames across parity and stop settings.
        single_frame(8'hA5, 2'd0, 1'b0);
        single_frame(8'hA5, 2'd1, 1'b0);
        single_frame(8'hA5, 2'd2, 1'b0);
        single_frame(8'hA5, 2'd2, 1'b1);
        single_frame(8'hA5, 2'd3, 1'b1);
        single_frame(8'h00, 2'd2, 1'b0);
        single_frame(8'hFF, 2'd1, 1'b1);

        // Mode change mid-frame must not disturb the frame in flight.
        wait_idle();
        parity_mode = 2'd1;
        stop2 = 0;
        send(8'hA7, w);
        repeat (5 * PW) @(negedge clk);
        parity_mode = 2'd2;
        stop2 = 1;
        send(8'hA7, w);

        // Full byte sweep, back-to-back, in every mode/stop combination.
        for (int c = 0; c < 8; c++) begin
            wait_idle();
            parity_mode = 2'(c % 4);
            stop2 = (c >= 4);
            for (int k = 0; k < 32; k++) send(8'(c * 32 + k), w);
        end

        // Reset during data bit 3 (0xF0 drives 0 there).
        wait_idle();
        parity_mode = 0;
        stop2 = 0;
        send(8'hF0, w);
        n = 0;
        while (tx_sig && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reset_test_start_seen", int'(tx_sig), 0);
        repeat (4 * PW + 2) @(negedge clk);
        chk("reset_test_pre_line", int'(tx_sig), 0);
        #1 rstn = 0;
        sb.delete();
        #1;
        chk("midframe_reset_tx_sig", int'(tx_sig), 1);
        chk("midframe_reset_busy", int'(busy), 0);
        chk("midframe_reset_ready", int'(tx_ready), 0);
        repeat (2) @(negedge clk);
        rstn = 1;
        single_frame(8'h3C, 2'd1, 1'b1);

`ifdef UART_TX_FIFO_EN
        wait_idle();
        parity_mode = 0;
        stop2 = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'(8'h10 + i), w);
            chk("fifo_no_stall", w, 0);
        end
        @(negedge clk);
        chk("fifo_full_ready", int'(tx_ready), 0);
        send(8'h15, w);
        chk("fifo_stall_seen", int'(w > 0), 1);
`endif

        // Random words, random gaps, random configuration per burst.
        for (int b = 0; b < 8; b++) begin
            wait_idle();
            parity_mode = 2'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            for (int k = 0; k < 5; k++) begin
                send(8'($urandom), w);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end

        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
